// File: rtl/rv32i_id_ex_stage.sv
// ---------------------------------------------------------------------------
// rv32i_id_ex_stage
//
// ID/EX pipeline register for a 5-stage RV32I core, with operand forwarding
// into the EX operands and load-use hazard detection back towards IF/ID.
//
// Configuration macros:
//   RV32I_FORWARDING_EN  when defined, o_rs1_data/o_rs2_data are taken from
//                        the EX/MEM or MEM/WB result if that stage writes the
//                        latched source register (x0 excluded). When
//                        undefined, the latched register data is passed
//                        straight through and the forwarding inputs are
//                        ignored.
//   ALU_OP_WIDTH         width of the ALU opcode field (defaults to 4).
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_stall, i_flush      hold EX contents / insert a bubble (flush wins)
//   i_id_* ... i_mem_write decoded instruction from ID
//   i_exmem_*, i_memwb_*  destination, write enable and result of later stages
//   o_* (mirrors of ID)   registered EX-stage fields driving the ALU
//   o_load_use_hazard     combinational request to stall IF/ID for one cycle
// ---------------------------------------------------------------------------
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module rv32i_id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic                     i_flush,

    input  logic                     i_id_valid,
    input  logic [`ALU_OP_WIDTH-1:0] i_alu_op,
    input  logic [3:0]               i_branch_op,
    input  logic                     i_alu_src_a,
    input  logic [1:0]               i_alu_src_b,
    input  logic [WIDTH-1:0]         i_pc,
    input  logic [WIDTH-1:0]         i_imm,
    input  logic [WIDTH-1:0]         i_rs1_data,
    input  logic [WIDTH-1:0]         i_rs2_data,
    input  logic [4:0]               i_rs1_addr,
    input  logic [4:0]               i_rs2_addr,
    input  logic [4:0]               i_rd_addr,
    input  logic                     i_reg_write,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,

    input  logic [4:0]               i_exmem_rd,
    input  logic                     i_exmem_reg_write,
    input  logic [WIDTH-1:0]         i_exmem_result,
    input  logic [4:0]               i_memwb_rd,
    input  logic                     i_memwb_reg_write,
    input  logic [WIDTH-1:0]         i_memwb_result,

    output logic                     o_valid,
    output logic [`ALU_OP_WIDTH-1:0] o_alu_op,
    output logic [3:0]               o_branch_op,
    output logic                     o_alu_src_a,
    output logic [1:0]               o_alu_src_b,
    output logic [WIDTH-1:0]         o_pc,
    output logic [WIDTH-1:0]         o_imm,
    output logic [WIDTH-1:0]         o_rs1_data,
    output logic [WIDTH-1:0]         o_rs2_data,
    output logic [4:0]               o_rd_addr,
    output logic                     o_reg_write,
    output logic                     o_mem_read,
    output logic                     o_mem_write,

    output logic                     o_load_use_hazard
);

    typedef struct packed {
        logic                     valid;
        logic [`ALU_OP_WIDTH-1:0] alu_op;
        logic [3:0]               branch_op;
        logic                     alu_src_a;
        logic [1:0]               alu_src_b;
        logic [WIDTH-1:0]         pc;
        logic [WIDTH-1:0]         imm;
        logic [WIDTH-1:0]         rs1_data;
        logic [WIDTH-1:0]         rs2_data;
        logic [4:0]               rs1_addr;
        logic [4:0]               rs2_addr;
        logic [4:0]               rd_addr;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
    } ex_reg_t;

    ex_reg_t ex_d;
    ex_reg_t ex_q;

    // Priority below reset: flush > stall > load.
    always_comb begin
        ex_d = ex_q;
        if (i_flush) begin
            ex_d = '0;
        end else if (!i_stall) begin
            ex_d.valid     = i_id_valid;
            ex_d.alu_op    = i_alu_op;
            ex_d.branch_op = i_branch_op;
            ex_d.alu_src_a = i_alu_src_a;
            ex_d.alu_src_b = i_alu_src_b;
            ex_d.pc        = i_pc;
            ex_d.imm       = i_imm;
            ex_d.rs1_data  = i_rs1_data;
            ex_d.rs2_data  = i_rs2_data;
            ex_d.rs1_addr  = i_rs1_addr;
            ex_d.rs2_addr  = i_rs2_addr;
            ex_d.rd_addr   = i_rd_addr;
            // Side effects of an invalid slot must never reach later stages.
            ex_d.reg_write = i_reg_write & i_id_valid;
            ex_d.mem_read  = i_mem_read  & i_id_valid;
            ex_d.mem_write = i_mem_write & i_id_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign o_valid     = ex_q.valid;
    assign o_alu_op    = ex_q.alu_op;
    assign o_branch_op = ex_q.branch_op;
    assign o_alu_src_a = ex_q.alu_src_a;
    assign o_alu_src_b = ex_q.alu_src_b;
    assign o_pc        = ex_q.pc;
    assign o_imm       = ex_q.imm;
    assign o_rd_addr   = ex_q.rd_addr;
    assign o_reg_write = ex_q.reg_write;
    assign o_mem_read  = ex_q.mem_read;
    assign o_mem_write = ex_q.mem_write;

`ifdef RV32I_FORWARDING_EN
    // Forwarding looks at the latched addresses, so it keeps tracking the
    // later stages while this register is held by a stall.
    logic rs1_exmem_hit;
    logic rs1_memwb_hit;
    logic rs2_exmem_hit;
    logic rs2_memwb_hit;

    assign rs1_exmem_hit = i_exmem_reg_write && (ex_q.rs1_addr != 5'd0)
                           && (i_exmem_rd == ex_q.rs1_addr);
    assign rs1_memwb_hit = i_memwb_reg_write && (ex_q.rs1_addr != 5'd0)
                           && (i_memwb_rd == ex_q.rs1_addr);
    assign rs2_exmem_hit = i_exmem_reg_write && (ex_q.rs2_addr != 5'd0)
                           && (i_exmem_rd == ex_q.rs2_addr);
    assign rs2_memwb_hit = i_memwb_reg_write && (ex_q.rs2_addr != 5'd0)
                           && (i_memwb_rd == ex_q.rs2_addr);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        o_rs1_data = ex_q.rs1_data;
        if (rs1_exmem_hit) begin
            o_rs1_data = i_exmem_result;
        end else if (rs1_memwb_hit) begin
            o_rs1_data = i_memwb_result;
        end
    end

    always_comb begin
        o_rs2_data = ex_q.rs2_data;
        if (rs2_exmem_hit) begin
            o_rs2_data = i_exmem_result;
        end else if (rs2_memwb_hit) begin
            o_rs2_data = i_memwb_result;
        end
    end
`else
    assign o_rs1_data = ex_q.rs1_data;
    assign o_rs2_data = ex_q.rs2_data;

    // Forwarding inputs and latched source addresses have no consumer here.
    logic unused_fwd;
    assign unused_fwd = ^{i_exmem_rd, i_exmem_reg_write, i_exmem_result,
                          i_memwb_rd, i_memwb_reg_write, i_memwb_result,
                          ex_q.rs1_addr, ex_q.rs2_addr};
`endif

    // A load in EX whose destination is read by the instruction in ID: its
    // data is not available until after MEM, so ID must wait one cycle.
    assign o_load_use_hazard = ex_q.valid && ex_q.mem_read
                               && (ex_q.rd_addr != 5'd0) && i_id_valid
                               && ((ex_q.rd_addr == i_rs1_addr)
                                   || (ex_q.rd_addr == i_rs2_addr));

endmodule

// File: tb/tb_rv32i_id_ex_stage.sv
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_rv32i_id_ex_stage;

`ifdef RV32I_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        rst, flush, stall, idv;
        logic [3:0]  alu_op, br;
        logic        sa;
        logic [1:0]  sb;
        logic [31:0] pc, imm, r1d, r2d;
        logic [4:0]  r1a, r2a, rd;
        logic        rw, mr, mw;
        logic [4:0]  xr;
        logic        xw;
        logic [31:0] xres;
        logic [4:0]  wr;
        logic        ww;
        logic [31:0] wres;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op, br;
        logic        sa;
        logic [1:0]  sb;
        logic [31:0] pc, imm, rs1, rs2;
        logic [4:0]  rd;
        logic        rw, mr, mw, haz;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_stall, i_flush, i_id_valid;
    logic [3:0]  i_alu_op, i_branch_op;
    logic        i_alu_src_a;
    logic [1:0]  i_alu_src_b;
    logic [31:0] i_pc, i_imm, i_rs1_data, i_rs2_data;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic        i_reg_write, i_mem_read, i_mem_write;
    logic [4:0]  i_exmem_rd, i_memwb_rd;
    logic        i_exmem_reg_write, i_memwb_reg_write;
    logic [31:0] i_exmem_result, i_memwb_result;

    logic        o_valid, o_alu_src_a, o_reg_write, o_mem_read, o_mem_write;
    logic [3:0]  o_alu_op, o_branch_op;
    logic [1:0]  o_alu_src_b;
    logic [31:0] o_pc, o_imm, o_rs1_data, o_rs2_data;
    logic [4:0]  o_rd_addr;
    logic        o_load_use_hazard;

    rv32i_id_ex_stage #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .i_alu_op(i_alu_op), .i_branch_op(i_branch_op),
        .i_alu_src_a(i_alu_src_a), .i_alu_src_b(i_alu_src_b),
        .i_pc(i_pc), .i_imm(i_imm), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_exmem_rd(i_exmem_rd), .i_exmem_reg_write(i_exmem_reg_write),
        .i_exmem_result(i_exmem_result), .i_memwb_rd(i_memwb_rd),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_result(i_memwb_result),
        .o_valid(o_valid), .o_alu_op(o_alu_op), .o_branch_op(o_branch_op),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_pc(o_pc), .o_imm(o_imm), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_load_use_hazard(o_load_use_hazard)
    );

    out_t  exp_q[$];
    bit    chk_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic apply(input in_t v);
        i_rst = v.rst; i_flush = v.flush; i_stall = v.stall; i_id_valid = v.idv;
        i_alu_op = v.alu_op; i_branch_op = v.br; i_alu_src_a = v.sa; i_alu_src_b = v.sb;
        i_pc = v.pc; i_imm = v.imm; i_rs1_data = v.r1d; i_rs2_data = v.r2d;
        i_rs1_addr = v.r1a; i_rs2_addr = v.r2a; i_rd_addr = v.rd;
        i_reg_write = v.rw; i_mem_read = v.mr; i_mem_write = v.mw;
        i_exmem_rd = v.xr; i_exmem_reg_write = v.xw; i_exmem_result = v.xres;
        i_memwb_rd = v.wr; i_memwb_reg_write = v.ww; i_memwb_result = v.wres;
    endtask

    // Inputs are applied just after the falling edge; the expectation is what
    // the outputs must show with those inputs present, before the next edge.
    task automatic step(input in_t v, input out_t e, input bit chk, input string nm);
        @(negedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
        chk_q.push_back(chk);
        name_q.push_back(nm);
    endtask

    function automatic out_t mk(input logic valid, input logic [3:0] alu,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic haz);
        out_t e;
        e = '0;
        e.valid = valid; e.alu_op = alu; e.pc = pc; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.haz = haz;
        return e;
    endfunction

    // Monitor: pops one expectation per presented sample and compares.
    initial begin
        out_t  e, a;
        bit    c;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) begin
                    a = '{o_valid, o_alu_op, o_branch_op, o_alu_src_a, o_alu_src_b,
                          o_pc, o_imm, o_rs1_data, o_rs2_data, o_rd_addr,
                          o_reg_write, o_mem_read, o_mem_write, o_load_use_hazard};
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL %s: got v=%b op=%h br=%h a=%b b=%h pc=%h imm=%h rs1=%h rs2=%h rd=%0d rw=%b mr=%b mw=%b haz=%b, expected v=%b op=%h br=%h a=%b b=%h pc=%h imm=%h rs1=%h rs2=%h rd=%0d rw=%b mr=%b mw=%b haz=%b",
                                 nm, a.valid, a.alu_op, a.br, a.sa, a.sb, a.pc, a.imm, a.rs1, a.rs2, a.rd, a.rw, a.mr, a.mw, a.haz,
                                 e.valid, e.alu_op, e.br, e.sa, e.sb, e.pc, e.imm, e.rs1, e.rs2, e.rd, e.rw, e.mr, e.mw, e.haz);
                    end
                end
            end
        end
    end

    initial begin
        in_t  v;
        out_t e;
        v = '0;
        v.rst = 1'b1;
        apply(v);

        // S0: hold reset across an edge
        step(v, '0, 1'b0, "init");

        // S1: reset state visible, idle input
        v = '0;
        step(v, '0, 1'b1, "reset_state");

        // S2: present full instruction; EX still holds the idle bubble
        v = '0; v.idv = 1; v.alu_op = 4'd3; v.br = 4'd5; v.sa = 1; v.sb = 2'd2;
        v.pc = 32'h100; v.imm = 32'h10; v.r1d = 32'h11; v.r2d = 32'h22;
        v.r1a = 5'd1; v.r2a = 5'd2; v.rd = 5'd4; v.rw = 1;
        step(v, '0, 1'b1, "before_load");

        // S3: invalid slot with side-effect bits set; check S2 capture
        e = mk(1, 4'd3, 32'h100, 32'h10, 32'h11, 32'h22, 5'd4, 1, 0, 0, 0);
        e.br = 4'd5; e.sa = 1; e.sb = 2'd2;
        v = '0; v.pc = 32'h200; v.rd = 5'd6; v.rw = 1; v.mr = 1; v.mw = 1;
        step(v, e, 1'b1, "plain_load");

        // S4: instruction reading x5/x9; check enable gating of S3
        e = mk(0, 0, 32'h200, 0, 0, 0, 5'd6, 0, 0, 0, 0);
        v = '0; v.idv = 1; v.r1a = 5'd5; v.r1d = 32'h1234; v.r2a = 5'd9; v.r2d = 32'h5678;
        v.rd = 5'd8; v.pc = 32'h300; v.rw = 1;
        step(v, e, 1'b1, "valid_gating");

        // S5: stall; EX/MEM and MEM/WB both write x5, EX/MEM wins
        e = mk(1, 0, 32'h300, 0, FWD ? 32'hDEAD : 32'h1234, 32'h5678, 5'd8, 1, 0, 0, 0);
        v = '0; v.stall = 1; v.xr = 5'd5; v.xw = 1; v.xres = 32'hDEAD;
        v.wr = 5'd5; v.ww = 1; v.wres = 32'hBEEF;
        step(v, e, 1'b1, "fwd_exmem_rs1");

        // S6: still stalled; only MEM/WB writes x5
        e = mk(1, 0, 32'h300, 0, FWD ? 32'hBEEF : 32'h1234, 32'h5678, 5'd8, 1, 0, 0, 0);
        v = '0; v.stall = 1; v.xr = 5'd7; v.xw = 0; v.xres = 32'hAAAA;
        v.wr = 5'd5; v.ww = 1; v.wres = 32'hBEEF;
        step(v, e, 1'b1, "fwd_memwb_rs1_stalled");

        // S7: release stall, new instruction reading x0/x7
        e = mk(1, 0, 32'h300, 0, FWD ? 32'hDEAD : 32'h1234, 32'h5678, 5'd8, 1, 0, 0, 0);
        v = '0; v.idv = 1; v.r1a = 5'd0; v.r1d = 32'h77; v.r2a = 5'd7; v.r2d = 32'h99;
        v.rd = 5'd10; v.pc = 32'h400; v.rw = 1; v.xr = 5'd5; v.xw = 1; v.xres = 32'hDEAD;
        step(v, e, 1'b1, "fwd_exmem_rs1_held");

        // S8: both later stages write x7
        e = mk(1, 0, 32'h400, 0, 32'h77, FWD ? 32'hAAAA : 32'h99, 5'd10, 1, 0, 0, 0);
        v = '0; v.stall = 1; v.xr = 5'd7; v.xw = 1; v.xres = 32'hAAAA;
        v.wr = 5'd7; v.ww = 1; v.wres = 32'hBBBB;
        step(v, e, 1'b1, "fwd_priority_rs2");

        // S9: both later stages target x0; latched rs1 is x0 too
        e = mk(1, 0, 32'h400, 0, 32'h77, 32'h99, 5'd10, 1, 0, 0, 0);
        v = '0; v.stall = 1; v.xr = 5'd0; v.xw = 1; v.xres = 32'hAAAA;
        v.wr = 5'd0; v.ww = 1; v.wres = 32'hBBBB;
        step(v, e, 1'b1, "fwd_x0_never");

        // S10: only MEM/WB writes x7
        e = mk(1, 0, 32'h400, 0, 32'h77, FWD ? 32'hBBBB : 32'h99, 5'd10, 1, 0, 0, 0);
        v = '0; v.stall = 1; v.xr = 5'd7; v.xw = 0; v.xres = 32'hAAAA;
        v.wr = 5'd7; v.ww = 1; v.wres = 32'hBBBB;
        step(v, e, 1'b1, "fwd_memwb_rs2");

        // S11: load x3 enters
        e = mk(1, 0, 32'h400, 0, 32'h77, 32'h99, 5'd10, 1, 0, 0, 0);
        v = '0; v.idv = 1; v.mr = 1; v.rw = 1; v.rd = 5'd3; v.pc = 32'h500;
        v.r1a = 5'd1; v.r2a = 5'd2; v.r1d = 32'h31; v.r2d = 32'h32;
        step(v, e, 1'b1, "no_fwd_no_hazard");

        // S12: consumer of x3 in ID (rs2); caller flushes this stage
        e = mk(1, 0, 32'h500, 0, 32'h31, 32'h32, 5'd3, 1, 1, 0, 1);
        v = '0; v.idv = 1; v.r1a = 5'd4; v.r2a = 5'd3; v.rd = 5'd9; v.pc = 32'h600;
        v.rw = 1; v.flush = 1;
        step(v, e, 1'b1, "load_use_rs2");

        // S13: bubble visible, hazard gone; next load x12 presented
        v = '0; v.idv = 1; v.pc = 32'h700; v.imm = 32'h70; v.alu_op = 4'd2; v.rd = 5'd12;
        v.r1a = 5'd12; v.r2a = 5'd13; v.mr = 1; v.rw = 1; v.r1d = 32'hA1; v.r2d = 32'hA2;
        step(v, '0, 1'b1, "after_flush");

        // S14..S16: three stalled cycles with changing ID inputs
        e = mk(1, 4'd2, 32'h700, 32'h70, 32'hA1, 32'hA2, 5'd12, 1, 1, 0, 0);
        v = '0; v.stall = 1; v.idv = 0; v.r1a = 5'd12;
        step(v, e, 1'b1, "hazard_needs_id_valid");

        e.haz = 1;
        v = '0; v.stall = 1; v.idv = 1; v.r1a = 5'd12; v.pc = 32'h800;
        step(v, e, 1'b1, "load_use_rs1_stalled");

        e.haz = 0;
        v = '0; v.stall = 1; v.idv = 1; v.pc = 32'hFFF; v.imm = 32'h5; v.rd = 5'd1;
        v.alu_op = 4'd9; v.rw = 1; v.mw = 1;
        step(v, e, 1'b1, "stall_hold_3");

        // S17: reset with flush and stall asserted; state still held here
        v = '0; v.rst = 1; v.flush = 1; v.stall = 1; v.idv = 1; v.pc = 32'h900;
        step(v, e, 1'b1, "stall_hold_pre_reset");

        // S18: everything cleared, stall keeps it cleared
        v = '0; v.stall = 1; v.idv = 1; v.r1a = 5'd12;
        step(v, '0, 1'b1, "reset_during_stall");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
